conv_seq_ctrl: RTL and testbench

// - Sequencer for the conv datapath in top: walks a KxK window over an IFM_H x IFM_W image held row-major in IFM BRAM.
// - Drives BRAM enable and ifm/weight addresses, and the MAC enable/clear that produce each 34-bit result.
// - Handshakes every finished output pixel to the downstream result consumer.

---
 rtl/conv_ctrl_pkg.sv | 31 +++
 rtl/conv_addr_gen.sv | 96 +++++++++
 rtl/conv_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and derived geometry for the convolution sequencer.
package conv_ctrl_pkg;

   // Default configuration of the conv datapath.
   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_IFM_W  = 8;
   localparam int unsigned DEF_IFM_H  = 8;
   localparam int unsigned DEF_K      = 3;
   localparam int unsigned DEF_RD_LAT = 1;

   // Sequencer states.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      DRAIN = 3'd2,
      EMIT  = 3'd3,
      FIN   = 3'd4
   } state_t;

   // Number of valid window positions along one image dimension.
   function automatic int unsigned out_dim(input int unsigned img, input int unsigned k);
      return img - k + 1;
   endfunction

   // Derived geometry of the default configuration.
   localparam int unsigned OUT_W = out_dim(DEF_IFM_W, DEF_K);
   localparam int unsigned OUT_H = out_dim(DEF_IFM_H, DEF_K);
   localparam int unsigned TAPS  = DEF_K * DEF_K;
   localparam int unsigned N_OUT = OUT_W * OUT_H;

endpackage

// File: rtl/conv_addr_gen.sv
// Window/tap counters and IFM/weight address generation for the conv sequencer.
module conv_addr_gen
   import conv_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned IFM_W  = DEF_IFM_W,
   parameter int unsigned IFM_H  = DEF_IFM_H,
   parameter int unsigned K      = DEF_K
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              step,
   input  logic              next_pix,
   input  logic              clr,
   output logic [ADDR_W-1:0] ifm_addr,
   output logic [ADDR_W-1:0] weight_addr,
   output logic              first_tap,
   output logic              last_tap,
   output logic              last_pix
);

   // One guard bit above the BRAM address width for the address sums.
   localparam int unsigned CW       = ADDR_W + 1;
   localparam int unsigned OUT_COLS = out_dim(IFM_W, K);
   localparam int unsigned OUT_ROWS = out_dim(IFM_H, K);

   logic [CW-1:0]     r_orow, r_ocol, r_kr, r_kc;
   logic [CW-1:0]     w_orow_nxt, w_ocol_nxt, w_kr_nxt, w_kc_nxt;
   logic [CW-1:0]     w_ifm_nxt, w_wgt_nxt;
   logic [ADDR_W-1:0] r_ifm_addr, r_weight_addr;
   logic              r_first_tap, r_last_tap, r_last_pix;

   // Next counter values and the addresses they select.
   always_comb begin
      w_orow_nxt = r_orow;
      w_ocol_nxt = r_ocol;
      w_kr_nxt   = r_kr;
      w_kc_nxt   = r_kc;
      if (clr) begin
         w_orow_nxt = '0;
         w_ocol_nxt = '0;
         w_kr_nxt   = '0;
         w_kc_nxt   = '0;
      end else if (next_pix) begin
         w_kr_nxt = '0;
         w_kc_nxt = '0;
         if (r_ocol == CW'(OUT_COLS - 1)) begin
            w_ocol_nxt = '0;
            w_orow_nxt = (r_orow == CW'(OUT_ROWS - 1)) ? '0 : r_orow + CW'(1);
         end else begin
            w_ocol_nxt = r_ocol + CW'(1);
         end
      end else if (step) begin
         if (r_kc == CW'(K - 1)) begin
            w_kc_nxt = '0;
            w_kr_nxt = (r_kr == CW'(K - 1)) ? '0 : r_kr + CW'(1);
         end else begin
            w_kc_nxt = r_kc + CW'(1);
         end
      end
      w_ifm_nxt = (w_orow_nxt + w_kr_nxt) * CW'(IFM_W) + w_ocol_nxt + w_kc_nxt;
      w_wgt_nxt = w_kr_nxt * CW'(K) + w_kc_nxt;
   end

   // Counters and registered address/flag outputs; a carry into the guard bit saturates.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_orow        <= '0;
         r_ocol        <= '0;
         r_kr          <= '0;
         r_kc          <= '0;
         r_ifm_addr    <= '0;
         r_weight_addr <= '0;
         r_first_tap   <= 1'b0;
         r_last_tap    <= 1'b0;
         r_last_pix    <= 1'b0;
      end else begin
         r_orow        <= w_orow_nxt;
         r_ocol        <= w_ocol_nxt;
         r_kr          <= w_kr_nxt;
         r_kc          <= w_kc_nxt;
         r_ifm_addr    <= w_ifm_nxt[ADDR_W] ? '1 : w_ifm_nxt[ADDR_W-1:0];
         r_weight_addr <= w_wgt_nxt[ADDR_W] ? '1 : w_wgt_nxt[ADDR_W-1:0];
         r_first_tap   <= (w_kr_nxt == '0) && (w_kc_nxt == '0);
         r_last_tap    <= (w_kr_nxt == CW'(K - 1)) && (w_kc_nxt == CW'(K - 1));
         r_last_pix    <= (w_orow_nxt == CW'(OUT_ROWS - 1)) && (w_ocol_nxt == CW'(OUT_COLS - 1));
      end
   end

   assign ifm_addr    = r_ifm_addr;
   assign weight_addr = r_weight_addr;
   assign first_tap   = r_first_tap;
   assign last_tap    = r_last_tap;
   assign last_pix    = r_last_pix;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: walks a KxK window over the IFM, drives BRAM reads,
// the MAC enable/clear pipe and the per-pixel result handshake.
module conv_seq_ctrl
   import conv_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned IFM_W  = DEF_IFM_W,
   parameter int unsigned IFM_H  = DEF_IFM_H,
   parameter int unsigned K      = DEF_K,
   parameter int unsigned RD_LAT = DEF_RD_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              ena,
   output logic [ADDR_W-1:0] ifm_addr,
   output logic [ADDR_W-1:0] weight_addr,
   output logic              mac_en,
   output logic              mac_clr,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ADDR_W-1:0] out_idx
);

   localparam int unsigned DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   // Reject geometries the address space or window cannot cover.
   if (64'(IFM_W) * 64'(IFM_H) > (64'(1) << ADDR_W)) begin : g_chk_size
      $error("conv_seq_ctrl: IFM_W*IFM_H exceeds 2**ADDR_W");
   end
   if (K > IFM_W || K > IFM_H) begin : g_chk_k
      $error("conv_seq_ctrl: kernel larger than image");
   end
   if (RD_LAT < 1 || RD_LAT > 2) begin : g_chk_lat
      $error("conv_seq_ctrl: RD_LAT must be 1 or 2");
   end

   state_t              r_state;
   logic                r_busy, r_done, r_ena, r_res_valid;
   logic [ADDR_W-1:0]   r_out_idx;
   logic [DRAIN_W-1:0]  r_drain_cnt;
   logic [RD_LAT-1:0]   r_en_pipe, r_clr_pipe;

   logic                w_clr, w_step, w_xfer;
   logic                w_first_tap, w_last_tap, w_last_pix;
   logic [ADDR_W-1:0]   w_ifm_addr, w_weight_addr;

   // Counter controls: clear on accepted start, step through taps, advance on transfer.
   assign w_clr  = (r_state == IDLE) && start;
   assign w_step = (r_state == LOAD) && !w_last_tap;
   assign w_xfer = (r_state == EMIT) && res_ready;

   conv_addr_gen #(
      .ADDR_W (ADDR_W),
      .IFM_W  (IFM_W),
      .IFM_H  (IFM_H),
      .K      (K)
   ) u_addr_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .step        (w_step),
      .next_pix    (w_xfer),
      .clr         (w_clr),
      .ifm_addr    (w_ifm_addr),
      .weight_addr (w_weight_addr),
      .first_tap   (w_first_tap),
      .last_tap    (w_last_tap),
      .last_pix    (w_last_pix)
   );

   // Sequencer FSM with registered control outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_ena       <= 1'b0;
         r_res_valid <= 1'b0;
         r_out_idx   <= '0;
         r_drain_cnt <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_state   <= LOAD;
                  r_busy    <= 1'b1;
                  r_ena     <= 1'b1;
                  r_out_idx <= '0;
               end
            end
            LOAD: begin
               if (w_last_tap) begin
                  r_state     <= DRAIN;
                  r_ena       <= 1'b0;
                  r_drain_cnt <= '0;
               end
            end
            DRAIN: begin
               if (r_drain_cnt == DRAIN_W'(RD_LAT - 1)) begin
                  r_state     <= EMIT;
                  r_res_valid <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
               end
            end
            EMIT: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  if (w_last_pix) begin
                     r_state <= FIN;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state   <= LOAD;
                     r_ena     <= 1'b1;
                     r_out_idx <= r_out_idx + ADDR_W'(1);
                  end
               end
            end
            FIN: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // MAC enable/clear follow the read enable by the BRAM read latency.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_en_pipe  <= '0;
         r_clr_pipe <= '0;
      end else begin
         r_en_pipe[0]  <= r_ena;
         r_clr_pipe[0] <= r_ena & w_first_tap;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            r_en_pipe[i]  <= r_en_pipe[i-1];
            r_clr_pipe[i] <= r_clr_pipe[i-1];
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign ena         = r_ena;
   assign ifm_addr    = w_ifm_addr;
   assign weight_addr = w_weight_addr;
   assign mac_en      = r_en_pipe[RD_LAT-1];
   assign mac_clr     = r_clr_pipe[RD_LAT-1];
   assign res_valid   = r_res_valid;
   assign out_idx     = r_out_idx;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl against a timeline model of the sequencer.
module tb_conv_seq_ctrl;

   localparam int IW = 8;
   localparam int IH = 8;
   localparam int KK = 3;
   localparam int AW = 8;
   localparam int OW = IW - KK + 1;
   localparam int OH = IH - KK + 1;
   localparam int NP = OW * OH;
   localparam int TP = KK * KK;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start, res_ready, sel;
   logic s1, s2, r1, r2;

   logic          b1_busy, b1_done, b1_ena, b1_mac_en, b1_mac_clr, b1_res_valid;
   logic [AW-1:0] b1_ifm_addr, b1_weight_addr, b1_out_idx;
   logic          b2_busy, b2_done, b2_ena, b2_mac_en, b2_mac_clr, b2_res_valid;
   logic [AW-1:0] b2_ifm_addr, b2_weight_addr, b2_out_idx;

   logic          c_busy, c_done, c_ena, c_mac_en, c_mac_clr, c_res_valid;
   logic [AW-1:0] c_ifm_addr, c_weight_addr, c_out_idx;

   int n_checks = 0;
   int n_err    = 0;

   assign s1 = start & ~sel;
   assign s2 = start & sel;
   assign r1 = res_ready & ~sel;
   assign r2 = res_ready & sel;

   conv_seq_ctrl #(.ADDR_W(AW), .IFM_W(IW), .IFM_H(IH), .K(KK), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(s1), .busy(b1_busy), .done(b1_done),
      .ena(b1_ena), .ifm_addr(b1_ifm_addr), .weight_addr(b1_weight_addr),
      .mac_en(b1_mac_en), .mac_clr(b1_mac_clr), .res_valid(b1_res_valid),
      .res_ready(r1), .out_idx(b1_out_idx)
   );

   conv_seq_ctrl #(.ADDR_W(AW), .IFM_W(IW), .IFM_H(IH), .K(KK), .RD_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(s2), .busy(b2_busy), .done(b2_done),
      .ena(b2_ena), .ifm_addr(b2_ifm_addr), .weight_addr(b2_weight_addr),
      .mac_en(b2_mac_en), .mac_clr(b2_mac_clr), .res_valid(b2_res_valid),
      .res_ready(r2), .out_idx(b2_out_idx)
   );

   assign c_busy        = sel ? b2_busy        : b1_busy;
   assign c_done        = sel ? b2_done        : b1_done;
   assign c_ena         = sel ? b2_ena         : b1_ena;
   assign c_mac_en      = sel ? b2_mac_en      : b1_mac_en;
   assign c_mac_clr     = sel ? b2_mac_clr     : b1_mac_clr;
   assign c_res_valid   = sel ? b2_res_valid   : b1_res_valid;
   assign c_ifm_addr    = sel ? b2_ifm_addr    : b1_ifm_addr;
   assign c_weight_addr = sel ? b2_weight_addr : b1_weight_addr;
   assign c_out_idx     = sel ? b2_out_idx     : b1_out_idx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},      32'(c_busy),        0);
      chk({tag, "_done"},      32'(c_done),        0);
      chk({tag, "_ena"},       32'(c_ena),         0);
      chk({tag, "_mac_en"},    32'(c_mac_en),      0);
      chk({tag, "_mac_clr"},   32'(c_mac_clr),     0);
      chk({tag, "_res_valid"}, 32'(c_res_valid),   0);
      chk({tag, "_ifm_addr"},  32'(c_ifm_addr),    0);
      chk({tag, "_wgt_addr"},  32'(c_weight_addr), 0);
      chk({tag, "_out_idx"},   32'(c_out_idx),     0);
   endtask

   // Process one whole image. Timeline model: pixel p reads on cycles s..s+TP-1,
   // holds its result from s+TP+lat until accepted, next pixel reads from the
   // cycle after the transfer. mode 0: always ready; 1: random ready and stray
   // start pulses; 2: first result stalled 5 cycles. exp_edge>0 checks the edge
   // index (counted from the start edge) of the last transfer.
   task automatic run_image(input int lat, input int mode, input int exp_edge);
      bit            ena_h [4096];
      bit            clr_h [4096];
      int            cyc, s, pix, t_last, stall, vfrom, tap, orow, ocol;
      bit            finished, in_read, in_valid, ex_mac, ex_clr, rdy;
      logic [AW-1:0] held;
      cyc = 0; s = 0; pix = 0; t_last = -1; stall = 0; finished = 0; held = '0;
      // res_ready raised with start must be ignored while idle
      start = 1'b1;
      res_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!finished && cyc < 4000) begin
         in_read  = (pix < NP) && (cyc >= s) && (cyc < s + TP);
         vfrom    = s + TP + lat;
         in_valid = (pix < NP) && (cyc >= vfrom);
         ex_mac   = (cyc >= lat) ? ena_h[cyc-lat] : 1'b0;
         ex_clr   = (cyc >= lat) ? clr_h[cyc-lat] : 1'b0;
         chk("ena",       32'(c_ena),       32'(in_read));
         chk("res_valid", 32'(c_res_valid), 32'(in_valid));
         chk("mac_en",    32'(c_mac_en),    32'(ex_mac));
         chk("mac_clr",   32'(c_mac_clr),   32'(ex_clr));
         chk("busy",      32'(c_busy),      32'(pix < NP));
         chk("done",      32'(c_done),      32'(pix == NP));
         if (in_read) begin
            tap  = cyc - s;
            orow = pix / OW;
            ocol = pix % OW;
            chk("ifm_addr", 32'(c_ifm_addr),    32'((orow + tap / KK) * IW + ocol + tap % KK));
            chk("wgt_addr", 32'(c_weight_addr), 32'(tap));
            ena_h[cyc] = 1'b1;
            clr_h[cyc] = (tap == 0);
         end
         if (in_valid) begin
            chk("out_idx", 32'(c_out_idx), 32'(pix));
            if (cyc == vfrom) held = c_ifm_addr;
            else chk("stall_addr", 32'(c_ifm_addr), 32'(held));
         end
         if (pix == NP) begin
            finished = 1'b1;
         end else begin
            case (mode)
               1:       rdy = 1'($urandom_range(0, 1));
               2:       rdy = !(pix == 0 && in_valid && stall < 5);
               default: rdy = 1'b1;
            endcase
            if (mode == 1) start = ($urandom_range(0, 7) == 0);
            if (in_valid && !rdy) stall++;
            res_ready = rdy;
            if (in_valid && rdy) begin
               pix++;
               s = cyc + 1;
               if (pix == NP) t_last = cyc;
            end
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      res_ready = 1'b0;
      chk("finished", 32'(finished), 1);
      if (exp_edge > 0) chk("last_xfer_edge", 32'(t_last + 1), 32'(exp_edge));
      if (mode == 2) chk("stall_cycles", 32'(stall), 5);
      @(negedge clk);
      chk("post_done", 32'(c_done), 0);
      chk("post_busy", 32'(c_busy), 0);
      chk("post_ena",  32'(c_ena),  0);
   endtask

   initial begin
      sel       = 1'b0;
      rst_n     = 1'b0;
      start     = 1'b1;
      res_ready = 1'b0;

      // reset held with start asserted: everything stays zero
      repeat (3) begin
         @(negedge clk);
         chk_all_zero("reset");
      end
      rst_n = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_busy", 32'(c_busy), 0);
      chk("idle_ena",  32'(c_ena),  0);

      // full image, consumer always ready
      run_image(1, 0, NP * (TP + 1 + 1));
      // first result stalled for 5 cycles
      run_image(1, 2, NP * (TP + 1 + 1) + 5);
      // random backpressure with stray start pulses
      run_image(1, 1, 0);

      // reset while issuing tap 4 aborts the image
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_tap4_ena", 32'(c_ena),         1);
      chk("abort_tap4_wgt", 32'(c_weight_addr), 4);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_ena",    32'(c_ena),    0);
      chk("abort_mac_en", 32'(c_mac_en), 0);
      chk("abort_busy",   32'(c_busy),   0);
      rst_n = 1'b1;
      @(negedge clk);
      // a fresh start begins again at the first window
      run_image(1, 0, NP * (TP + 1 + 1));

      // two-cycle BRAM latency instance
      sel = 1'b1;
      @(negedge clk);
      chk_all_zero("lat2_idle");
      run_image(2, 0, NP * (TP + 2 + 1));
      run_image(2, 1, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
